// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational shift-add multiplier among NREQ requesters.
// Define MULT_ARB_PIPE_EN to add an operand register stage ahead of the multiplier (latency 2).

module multiplier #(
  parameter int N = 16
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++)
      if (b[i]) p = p + ({{N{1'b0}}, a} << i);
  end

endmodule

module mult_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*N-1:0]    res_p,
  output logic [IDW-1:0]    res_id
);

  logic            stall;
  logic            accept;
  logic            any_req;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant;
  logic [NREQ-1:0] rot;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic [N-1:0]    mul_a;
  logic [N-1:0]    mul_b;
  logic [2*N-1:0]  prod;

  assign any_req = |req_valid;
  assign stall   = res_valid & ~res_ready;

  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> rr_ptr);
    grant = rr_ptr;
    for (int off = NREQ - 1; off >= 0; off--)
      if (rot[off]) grant = IDW'((int'(rr_ptr) + off) % NREQ);
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a        = req_a[i*N +: N];
        sel_b        = req_b[i*N +: N];
        req_ready[i] = accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= IDW'((int'(grant) + 1) % NREQ);
  end

  multiplier #(.N(N)) u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

`ifdef MULT_ARB_PIPE_EN
  logic           advance;
  logic           vld_p0;
  logic [N-1:0]   a_p0;
  logic [N-1:0]   b_p0;
  logic [IDW-1:0] id_p0;

  assign advance = ~stall;
  assign accept  = any_req & (~vld_p0 | advance) & ~rst;
  assign mul_a   = a_p0;
  assign mul_b   = b_p0;

  // Stage p0: operand register; only loads on accept, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= accept | (vld_p0 & ~advance);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= sel_a;
      b_p0  <= sel_b;
      id_p0 <= grant;
    end
  end

  // Stage p1: result register, fed by the multiplier output of stage p0.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_p     <= '0;
      res_id    <= '0;
    end else if (advance) begin
      res_valid <= vld_p0;
      if (vld_p0) begin
        res_p  <= prod;
        res_id <= id_p0;
      end
    end
  end
`else
  assign accept = any_req & ~stall & ~rst;
  assign mul_a  = sel_a;
  assign mul_b  = sel_b;

  // Stage p0: result register; a new accept overwrites a draining result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_p     <= '0;
      res_id    <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_p     <= prod;
      res_id    <= grant;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter with a transaction-queue reference model.
// Honours MULT_ARB_PIPE_EN to match the build under test.

module tb_mult_arbiter;
  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [2*N-1:0]    res_p;
  logic [IDW-1:0]    res_id;

  mult_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [2*N-1:0] p;
  } ent_t;

  ent_t q[$];
  int   m_rr   = 0;
  logic m_out  = 1'b0;
  logic m_s1   = 1'b0;
  logic synced = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check against the model, then advance the model at the edge.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*N-1:0] av,
                       input logic [NREQ*N-1:0] bv, input logic rdy, input logic r);
    int   g;
    logic acc;
    logic adv;
    logic [2*N-1:0] pr;
    @(negedge clk);
    req_valid = v;
    req_a     = av;
    req_b     = bv;
    res_ready = rdy;
    rst       = r;
    #1;
    g = 0;
    for (int off = NREQ - 1; off >= 0; off--)
      if (v[2'((m_rr + off) % NREQ)]) g = (m_rr + off) % NREQ;
    adv = !(m_out && !rdy);
`ifdef MULT_ARB_PIPE_EN
    acc = (v != 0) && (!m_s1 || adv) && !r;
`else
    acc = (v != 0) && adv && !r;
`endif
    if (synced || r)
      chk("req_ready", 64'(req_ready), acc ? (64'd1 << g) : 64'd0);
    if (synced) begin
      chk("res_valid", 64'(res_valid), 64'(m_out));
      if (m_out && q.size() > 0) begin
        chk("res_p", 64'(res_p), 64'(q[0].p));
        chk("res_id", 64'(res_id), 64'(q[0].id));
      end
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_out  = 1'b0;
      m_s1   = 1'b0;
      m_rr   = 0;
      synced = 1'b1;
    end else begin
      if (m_out && rdy) void'(q.pop_front());
      if (acc) begin
        pr = 32'(av[g*N +: N]) * 32'(bv[g*N +: N]);
        q.push_back('{IDW'(g), pr});
        m_rr = (g + 1) % NREQ;
      end
`ifdef MULT_ARB_PIPE_EN
      if (adv) begin
        m_out = m_s1;
        m_s1  = acc;
      end else if (acc) begin
        m_s1 = 1'b1;
      end
`else
      if (adv) m_out = acc;
`endif
    end
  endtask

  function automatic logic [NREQ*N-1:0] rnd_ops();
    logic [NREQ*N-1:0] x;
    for (int i = 0; i < NREQ; i++) begin
      case ($urandom_range(0, 7))
        0:       x[i*N +: N] = '1;
        1:       x[i*N +: N] = '0;
        default: x[i*N +: N] = N'($urandom);
      endcase
    end
    return x;
  endfunction

  initial begin
    cycle('0, '0, '0, 1'b1, 1'b1);
    cycle('0, '0, '0, 1'b1, 1'b1);

`ifdef MULT_ARB_PIPE_EN
    cycle(4'b0001, 64'd7, 64'd9, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b1, 1'b0);
    #1;
    chk("t6_valid", 64'(res_valid), 64'd1);
    chk("t6_p", 64'(res_p), 64'd63);
    chk("t6_id", 64'(res_id), 64'd0);
`else
    cycle(4'b0001, 64'd3, 64'd5, 1'b1, 1'b0);
    #1;
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_p", 64'(res_p), 64'd15);
    chk("t1_id", 64'(res_id), 64'd0);
`endif
    cycle('0, '0, '0, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b1, 1'b0);

    cycle(4'b0100, 64'hFFFF << (2*N), 64'hFFFF << (2*N), 1'b1, 1'b0);
`ifdef MULT_ARB_PIPE_EN
    cycle('0, '0, '0, 1'b1, 1'b0);
`endif
    #1;
    chk("t3_p", 64'(res_p), 64'hFFFE0001);
    chk("t3_id", 64'(res_id), 64'd2);

    for (int i = 0; i < 12; i++) cycle(4'b1111, rnd_ops(), rnd_ops(), 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) cycle(4'b1010, rnd_ops(), rnd_ops(), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(4'b1010, rnd_ops(), rnd_ops(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle('0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) cycle(4'b1111, rnd_ops(), rnd_ops(), 1'b1, 1'b0);
    cycle(4'b1111, rnd_ops(), rnd_ops(), 1'b0, 1'b1);
    #1;
    chk("t5_valid", 64'(res_valid), 64'd0);
    chk("t5_p", 64'(res_p), 64'd0);
    chk("t5_id", 64'(res_id), 64'd0);
    for (int i = 0; i < 6; i++) cycle(4'b1111, rnd_ops(), rnd_ops(), 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++)
      cycle(NREQ'($urandom), rnd_ops(), rnd_ops(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 249) == 0));
    for (int i = 0; i < 4; i++) cycle('0, '0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
